// File: rtl/key_shift_register.sv
// Debounced two-key editor for a WIDTH-bit LED value: shift, rotate and count modes,
// chord-to-clear and hold-to-repeat.
module key_shift_register #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CHORD_WINDOW    = 2500000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clock_50,
  input  logic             reset_n,
  input  logic [1:0]       key,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] value,
  output logic             step
);

  localparam int MAX_AB = (CHORD_WINDOW > REPEAT_DELAY) ? CHORD_WINDOW : REPEAT_DELAY;
  localparam int TMAX   = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int DW     = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [TW-1:0] CW_LAST = TW'(CHORD_WINDOW - 1);
  localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RP_LAST = TW'(REPEAT_PERIOD - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CHORD_WAIT, HOLD, WAIT_RELEASE} state_t;

  logic [1:0]    sync_p0, sync_p1;
  logic [1:0]    key_db;
  logic [DW-1:0] db_cnt [2];

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          key_sel, key_sel_nxt;
  logic          rep, rep_nxt;
  logic          do_act, do_clr;
  logic [1:0]    pressed;

  // key_sel: 0 = key[0] (inserts 1 / rotates left / increments), 1 = key[1]
  function automatic logic [WIDTH-1:0] edit(input logic [WIDTH-1:0] v,
                                            input logic [1:0] m,
                                            input logic k);
    case (m)
      2'd0:    edit = {v[WIDTH-2:0], ~k};
      2'd1:    edit = {~k, v[WIDTH-1:1]};
      2'd2:    edit = k ? {v[0], v[WIDTH-1:1]} : {v[WIDTH-2:0], v[WIDTH-1]};
      default: edit = k ? v - WIDTH'(1) : v + WIDTH'(1);
    endcase
  endfunction

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
    sat_inc = (&t) ? t : t + TW'(1);
  endfunction

  // Stage p0/p1: two-flop synchroniser on the raw key levels
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= key;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: accept a level only after it has differed from key_db for the full count
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      key_db <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == key_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          key_db[i] <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign pressed = key_sel ? 2'b10 : 2'b01;

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    key_sel_nxt = key_sel;
    rep_nxt     = rep;
    do_act      = 1'b0;
    do_clr      = 1'b0;
    case (state)
      IDLE: begin
        if (key_db == 2'b11) begin
          do_clr    = 1'b1;
          state_nxt = WAIT_RELEASE;
        end else if (key_db != 2'b00) begin
          key_sel_nxt = key_db[1];
          timer_nxt   = '0;
          state_nxt   = CHORD_WAIT;
        end
      end
      CHORD_WAIT: begin
        if (key_db == 2'b11) begin
          do_clr    = 1'b1;
          state_nxt = WAIT_RELEASE;
        end else if (key_db == 2'b00) begin
          do_act    = 1'b1;
          state_nxt = IDLE;
        end else if (key_db != pressed) begin
          state_nxt = IDLE;
        end else if (timer == CW_LAST) begin
          do_act    = 1'b1;
          timer_nxt = '0;
          rep_nxt   = 1'b0;
          state_nxt = HOLD;
        end else begin
          timer_nxt = sat_inc(timer);
        end
      end
      HOLD: begin
        if (key_db == 2'b00 || key_db != pressed && key_db != 2'b11) begin
          state_nxt = IDLE;
        end else if (key_db == 2'b11) begin
          state_nxt = WAIT_RELEASE;
        end else if (REPEAT_EN != 0 && timer == (rep ? RP_LAST : RD_LAST)) begin
          do_act    = 1'b1;
          timer_nxt = '0;
          rep_nxt   = 1'b1;
        end else begin
          timer_nxt = sat_inc(timer);
        end
      end
      WAIT_RELEASE: begin
        if (key_db == 2'b00) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p2: registered FSM state and value/step outputs
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      timer   <= '0;
      key_sel <= 1'b0;
      rep     <= 1'b0;
      value   <= '0;
      step    <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      key_sel <= key_sel_nxt;
      rep     <= rep_nxt;
      step    <= do_act | do_clr;
      if (do_clr)      value <= '0;
      else if (do_act) value <= edit(value, mode, key_sel);
    end
  end

endmodule

// File: tb/tb_key_shift_register.sv
// Bench for key_shift_register: directed scenarios plus random key traffic, compared each
// cycle against an event-time reference model (two DUTs: repeat enabled and disabled).
module tb_key_shift_register;
  localparam int W  = 4;
  localparam int DB = 4;
  localparam int CW = 8;
  localparam int RD = 20;
  localparam int RP = 5;
  localparam int M  = 1 << W;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   key;
  logic [1:0]   mode;
  logic [W-1:0] value_a, value_b;
  logic         step_a, step_b;

  key_shift_register #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .CHORD_WINDOW(CW), .REPEAT_EN(1),
                       .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
    dut_a (.clock_50(clk), .reset_n(reset_n), .key(key), .mode(mode), .value(value_a), .step(step_a));

  key_shift_register #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .CHORD_WINDOW(CW), .REPEAT_EN(0),
                       .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
    dut_b (.clock_50(clk), .reset_n(reset_n), .key(key), .mode(mode), .value(value_b), .step(step_b));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int steps_a = 0;
  int steps_b = 0;

  // reference model: synchroniser/debounce history plus press-time bookkeeping per DUT
  int         cyc = 0;
  logic [1:0] s1m = '0, s2m = '0, dbm = '0;
  logic [1:0] hist[$];
  int         vm[2];
  logic       sm[2];
  int         ph[2];
  int         pm[2];
  int         km[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int edit_m(input int v, input int m, input int k);
    int ins;
    ins = (k == 0) ? 1 : 0;
    case (m)
      0:       return (v * 2 + ins) % M;
      1:       return v / 2 + ins * (M / 2);
      2:       return (k != 0) ? (v / 2 + (v % 2) * (M / 2)) : ((v * 2) % M + v / (M / 2));
      default: return (k != 0) ? (v + M - 1) % M : (v + 1) % M;
    endcase
  endfunction

  task automatic act_m(input int i, input int md);
    vm[i] = edit_m(vm[i], md, km[i]);
    sm[i] = 1'b1;
  endtask

  task automatic fsm_m(input int i, input int md, input int ren);
    int   e;
    int   kc;
    logic single;
    sm[i]  = 1'b0;
    single = (dbm == 2'b01) || (dbm == 2'b10);
    kc     = (dbm == 2'b10) ? 1 : 0;
    case (ph[i])
      0: begin
        if (dbm == 2'b11) begin
          vm[i] = 0; sm[i] = 1'b1; ph[i] = 2;
        end else if (single) begin
          ph[i] = 1; pm[i] = cyc; km[i] = kc;
        end
      end
      1: begin
        e = cyc - pm[i];
        if (dbm == 2'b11) begin
          if (e <= CW) begin vm[i] = 0; sm[i] = 1'b1; end
          ph[i] = 2;
        end else if (dbm == 2'b00) begin
          if (e <= CW) act_m(i, md);
          ph[i] = 0;
        end else if (kc != km[i]) begin
          ph[i] = 0;
        end else if (e == CW || (ren != 0 && e >= CW + RD && (e - CW - RD) % RP == 0)) begin
          act_m(i, md);
        end
      end
      default: if (dbm == 2'b00) ph[i] = 0;
    endcase
  endtask

  task automatic tick();
    logic [1:0] kin, newdb;
    int         md;
    logic       rin, flip;
    kin = key; md = int'(mode); rin = reset_n;
    @(posedge clk);
    if (!rin) begin
      s1m = '0; s2m = '0; dbm = '0; hist.delete();
      for (int i = 0; i < 2; i++) begin vm[i] = 0; sm[i] = 1'b0; ph[i] = 0; end
    end else begin
      fsm_m(0, md, 1);
      fsm_m(1, md, 0);
      newdb = dbm;
      hist.push_back(s2m);
      if (hist.size() > DB) void'(hist.pop_front());
      if (hist.size() == DB) begin
        for (int b = 0; b < 2; b++) begin
          flip = 1'b1;
          foreach (hist[j]) if (hist[j][b] == dbm[b]) flip = 1'b0;
          if (flip) newdb[b] = ~dbm[b];
        end
      end
      dbm = newdb; s2m = s1m; s1m = kin;
      cyc++;
    end
    @(negedge clk);
    check("value_a", 32'(value_a), vm[0]);
    check("step_a", 32'(step_a), 32'(sm[0]));
    check("value_b", 32'(value_b), vm[1]);
    check("step_b", 32'(step_b), 32'(sm[1]));
    if (step_a === 1'b1) steps_a++;
    if (step_b === 1'b1) steps_b++;
  endtask

  task automatic run(input logic [1:0] k, input int n);
    key = k;
    repeat (n) tick();
  endtask

  initial begin
    int exp_tap[3];
    int lat;
    logic [1:0] rk;
    exp_tap = '{1, 3, 7};
    reset_n = 1'b0; key = 2'b00; mode = 2'd0;
    for (int i = 0; i < 2; i++) begin vm[i] = 0; sm[i] = 1'b0; ph[i] = 0; pm[i] = 0; km[i] = 0; end
    run(2'b00, 3);
    check("reset_value", 32'(value_a), 0);
    check("reset_step", 32'(step_a), 0);
    reset_n = 1'b1;
    run(2'b00, 5);

    // taps of key[0] in shift-left mode
    steps_a = 0;
    for (int t = 0; t < 3; t++) begin
      run(2'b01, 6);
      run(2'b00, 15);
      check("tap_value", 32'(value_a), exp_tap[t]);
    end
    check("tap_steps", steps_a, 3);

    // bouncing key[1] never settles
    steps_a = 0;
    repeat (5) begin run(2'b10, 3); run(2'b00, 1); end
    run(2'b00, 20);
    check("bounce_value", 32'(value_a), 7);
    check("bounce_steps", steps_a, 0);
    mode = 2'd1;
    run(2'b10, 6);
    run(2'b00, 15);
    check("shr_value", 32'(value_a), 3);

    // chord clears once
    mode = 2'd0; steps_a = 0;
    run(2'b01, 3);
    run(2'b11, 30);
    run(2'b00, 20);
    check("chord_value", 32'(value_a), 0);
    check("chord_steps", steps_a, 1);

    // counter wraps both ways
    mode = 2'd3;
    run(2'b10, 6); run(2'b00, 15);
    check("dec_wrap", 32'(value_a), 15);
    run(2'b01, 6); run(2'b00, 15);
    check("inc_wrap", 32'(value_a), 0);
    run(2'b01, 6); run(2'b00, 15);
    check("inc_value", 32'(value_a), 1);

    // hold key[0] in rotate mode: 66 debounced cycles -> actions at +8,+28,+33..+63
    mode = 2'd2; steps_a = 0; steps_b = 0;
    run(2'b01, 66);
    run(2'b00, 20);
    check("hold_steps_rep", steps_a, 9);
    check("hold_steps_norep", steps_b, 1);
    check("hold_value_rep", 32'(value_a), 2);
    check("hold_value_norep", 32'(value_b), 2);

    // reset while repeating with key held
    run(2'b01, 40);
    reset_n = 1'b0;
    run(2'b01, 3);
    check("midreset_value", 32'(value_a), 0);
    check("midreset_step", 32'(step_a), 0);
    reset_n = 1'b1;
    lat = 0;
    for (int n = 1; n <= 100 && lat == 0; n++) begin
      tick();
      if (step_a === 1'b1) lat = n;
    end
    check("reset_latency", lat, DB + 2 + CW + 1);
    run(2'b00, 20);

    // random key traffic and mode changes
    for (int s = 0; s < 60; s++) begin
      mode = 2'($urandom_range(0, 3));
      rk   = 2'($urandom_range(0, 3));
      run(rk, int'($urandom_range(1, 35)));
    end
    run(2'b00, 30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
